// File: rtl/mem_arbiter_if.sv
// Core, debug-loader and memory-macro signals around the unified-memory arbiter.
// Latency: wiring only, no registers.
// Backpressure: each requester holds req and its fields until its own done pulse.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // core side
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_done;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  // debug / program-loader side
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;
  // memory macro side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;

  // arbiter view
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_done, core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_done, dbg_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata,
    output busy
  );

  // requester / memory-model view
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_done, core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_done, dbg_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between the core and the debug loader, one transaction at a time.
// Latency: request sampled in IDLE -> done pulse WAIT_STATES+2 cycles later; WAIT_STATES+3 cycles per transaction.
// Backpressure: requests are only sampled in IDLE; core_stall holds the control FSM until core_done.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state;
  state_t            state_nxt;
  logic              owner_dbg;    // 1 = current transaction belongs to the debug port
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              any_req;
  logic              grant_dbg;
  logic              last_access;

  assign any_req     = bus.core_req | bus.dbg_req;
  // core has priority unless the debug port has been passed over STARVE_LIMIT times
  assign grant_dbg   = bus.dbg_req & (~bus.core_req | (starve_cnt == STARVE_MAX));
  assign last_access = (state == S_ACCESS) && (wait_cnt == 4'd0);

  // state register; reset aborts any transaction in flight
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: IDLE -> ACCESS on any request, ACCESS until wait states expire, DONE for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: if (wait_cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // outputs: memory strobes only in ACCESS, write strobe on the final ACCESS cycle, done in DONE
  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.core_done = 1'b0;
    bus.dbg_done  = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      S_ACCESS: begin
        bus.mem_re = ~we_q;
        bus.mem_we = we_q & (wait_cnt == 4'd0);
        bus.busy   = 1'b1;
      end
      S_DONE: begin
        bus.core_done = ~owner_dbg;
        bus.dbg_done  = owner_dbg;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // latch owner and request fields at grant; they keep driving the memory bus until the next grant
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      owner_dbg <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (state == S_IDLE && any_req) begin
      owner_dbg <= grant_dbg;
      we_q      <= grant_dbg ? bus.dbg_we    : bus.core_we;
      addr_q    <= grant_dbg ? bus.dbg_addr  : bus.core_addr;
      wdata_q   <= grant_dbg ? bus.dbg_wdata : bus.core_wdata;
    end
  end

  // wait-state counter: reloaded while idle, counts down through ACCESS
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                                   wait_cnt <= 4'd0;
    else if (state == S_IDLE)                     wait_cnt <= WAIT_INIT;
    else if (state == S_ACCESS && wait_cnt != 0)  wait_cnt <= wait_cnt - 4'd1;
  end

  // starvation counter: counts core grants that passed over a pending debug request
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      starve_cnt <= 4'd0;
    end else if (state == S_IDLE) begin
      if (!bus.dbg_req || grant_dbg)
        starve_cnt <= 4'd0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // read data capture into the owner's register only, on the final ACCESS cycle
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else if (last_access && !we_q) begin
      if (owner_dbg) dbg_rdata_q  <= bus.mem_rdata;
      else           core_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.core_stall = bus.core_req & ~bus.core_done;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported 16-bit unified memory between the multi-cycle core (the control FSM's MemR/MemW/IoD path) and the debug/program-loader port. The block runs one memory transaction at a time. It holds each transaction for a programmable number of wait states and returns read data with a one-cycle done pulse. Arbitration favours the core, with a starvation guard for the debug port. It sits between the core datapath memory mux and the memory macro.

## Interface

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT_STATES, 1, extra memory cycles per access (0..15)
- STARVE_LIMIT, 4, consecutive core grants with debug pending before debug is forced (1..15)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- core_req  in  1  core transaction request; held until core_done
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_done  out  1  one-cycle completion pulse
- core_rdata  out  DATA_W  registered read data, valid from core_done onward
- core_stall  out  1  core_req high and transaction not yet done; feeds the control FSM hold
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug-port equivalents
- dbg_done  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid on the final ACCESS cycle
- busy  out  1  high in ACCESS or DONE

## Operation

- States:
  - IDLE: samples requests. If any request is high, latch the owner, we, addr and wdata, load wait_cnt = WAIT_STATES, and go to ACCESS.
  - ACCESS: mem_addr and mem_wdata are driven from the latches. mem_re = ~we for every ACCESS cycle. mem_we = we only on the cycle wait_cnt == 0. wait_cnt decrements each cycle. When wait_cnt == 0: if read, capture mem_rdata into the owner's rdata register; then go to DONE.
  - DONE: assert the owner's done for exactly this cycle, then return to IDLE. Requests are not sampled in DONE.
- Arbitration in IDLE:
  - Only one requester high: grant it.
  - Both high: the core wins unless starve_cnt == STARVE_LIMIT, in which case debug wins.
- starve_cnt (4 bits):
  - Increments on each core grant while dbg_req is high, saturating at STARVE_LIMIT.
  - Clears on any debug grant, and on any IDLE cycle with dbg_req low.
- Requester handshake:
  - Inputs must be held stable while req is high, until done.
  - The requester drops req on the edge where it samples done = 1, unless it issues a back-to-back request with new fields.
  - A req still high in the IDLE cycle after DONE is a new transaction.
- Request inputs are ignored outside IDLE. An abandoned request (req dropped mid-transaction) still completes, and done still pulses.
- Only the owner's rdata register is written; the other holds its value.
- core_stall = core_req & ~core_done, combinational.
- Outside ACCESS, mem_re = mem_we = 0 and mem_addr/mem_wdata hold their last values.
- Reset low, at any time including mid-ACCESS:
  - State goes to IDLE; the transaction is aborted with no done and no mem_we.
  - starve_cnt = 0.
  - All outputs 0: mem_*, rdata registers, done, busy. core_stall follows core_req.

## Timing

- Request sampled in IDLE at cycle t: ACCESS occupies t+1 .. t+1+WAIT_STATES, DONE at t+2+WAIT_STATES.
- Latency from sample to done = WAIT_STATES + 2 cycles. Each transaction occupies WAIT_STATES + 3 cycles including IDLE.
- mem_we is high for exactly one cycle per write. Each transaction produces exactly one done pulse.
- With WAIT_STATES = 0, ACCESS lasts one cycle.
- rdata is stable from the DONE cycle until that requester's next read completes.
- Simultaneous reset release and request: the first IDLE cycle after Reset goes high samples normally.

## Test plan

- Core read, WAIT_STATES=1, memory [0x0040]=0xBEEF, core_req at cycle 0:
  - mem_re high cycles 1–2.
  - core_done pulses at cycle 3 with core_rdata=0xBEEF.
  - core_stall high cycles 0–2.
- Core write 0x1234 to 0x0010:
  - mem_we high for exactly one cycle (cycle 2) with addr 0x0010 and data 0x1234.
  - Readback via the debug port returns 0x1234.
- Both requesters continuously requesting, STARVE_LIMIT=4:
  - Grant sequence is core×4, dbg, core×4, dbg.
  - dbg_done spacing is 5×(WAIT_STATES+3) cycles.
- Only dbg_req high, with core idle: immediate debug grant, latency WAIT_STATES+2, starve_cnt stays 0.
- Reset asserted in the second ACCESS cycle of a write:
  - No mem_we pulse, no done.
  - All outputs 0 during reset.
  - After release, a pending core_req is served from IDLE with full latency.
- WAIT_STATES=0, back-to-back core reads of 0x0001 then 0x0002:
  - core_done pulses three cycles apart with correct data.
  - dbg_rdata is unchanged throughout.
